// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Both helpers return at least 1 so a degenerate parameter never yields a zero-width vector.
    function automatic int cnt_width(input int clks_per_bit);
        return ($clog2(clks_per_bit) < 1) ? 1 : $clog2(clks_per_bit);
    endfunction

    function automatic int idx_width(input int data_bits);
        return ($clog2(data_bits) < 1) ? 1 : $clog2(data_bits);
    endfunction

endpackage

// File: rtl/uart_xmit_controller_parity.sv
// Running parity accumulator; XORs Din in on each Enable, cleared by Reset.
module Xmit_ParityGenerator (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    input  logic Din,
    output logic Parity
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Parity <= 1'b0;
        end else if (Enable) begin
            Parity <= Parity ^ Din;
        end
    end

endmodule

// File: rtl/uart_xmit_controller.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop bit(s).
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | start bit (low)
// DATA   | shifting data bits out LSB-first
// PARITY | parity bit
// STOP   | stop bit(s) (high); last cycle may accept the next byte
module uart_xmit_controller
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [DATA_BITS-1:0] TxData,
    input  logic                 TxValid,
    output logic                 TxReady,
    output logic                 TxOut,
    output logic                 TxBusy
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int BW = idx_width(DATA_BITS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT  = 1'(PARITY_ODD);

    tx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  par_clr_q;
    logic                  par_en;
    logic                  par;
    logic                  bit_end;
    logic                  stop_last;
    logic                  accept;

    assign bit_end   = (cnt_q == '0);
    assign stop_last = (STOP_BITS == 2) ? stop_q : 1'b1;
    assign TxReady   = (state_q == ST_IDLE) ||
                       ((state_q == ST_STOP) && bit_end && stop_last);
    assign accept    = TxValid && TxReady;
    assign TxOut     = tx_q;
    assign TxBusy    = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_en  = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? CNT_LOAD : cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    shift_d = TxData;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                par_en = (cnt_q == CNT_LOAD);
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_last) begin
                        if (accept) begin
                            state_d = ST_START;
                            shift_d = TxData;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is computed from the next state so TxOut comes straight from a flop.
    always_comb begin
        tx_d = LINE_IDLE;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par ^ ODD_BIT;
            default:   tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
            tx_q      <= LINE_IDLE;
            par_clr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            par_clr_q <= (state_d == ST_IDLE) || (state_d == ST_STOP);
        end
    end

    // par_clr_q mirrors "state is IDLE or STOP" from a flop, keeping the generator clear glitch-free.
    Xmit_ParityGenerator u_parity (
        .Clock  (Clock),
        .Reset  (Reset | par_clr_q),
        .Enable (par_en),
        .Din    (shift_q[0]),
        .Parity (par)
    );

endmodule

// File: tb/tb_uart_xmit_controller.sv
// Bench: three configurations driven in lockstep, checked every cycle against a frame-queue model.
module tb_uart_xmit_controller;

    localparam int CPB = 4;

    logic       Clock;
    logic       Reset;
    logic [7:0] TxData;
    logic       TxValid;
    logic [2:0] tx_out, rdy, bsy;

    // instance 0: even parity, 1 stop; 1: odd parity, 1 stop; 2: no parity, 2 stops
    int pen_cfg  [3] = '{1, 1, 0};
    int odd_cfg  [3] = '{0, 1, 0};
    int stop_cfg [3] = '{1, 1, 2};

    uart_xmit_controller #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                           .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .Clock(Clock), .Reset(Reset), .TxData(TxData), .TxValid(TxValid),
        .TxReady(rdy[0]), .TxOut(tx_out[0]), .TxBusy(bsy[0]));

    uart_xmit_controller #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                           .PARITY_ODD(1), .STOP_BITS(1)) dut_b (
        .Clock(Clock), .Reset(Reset), .TxData(TxData), .TxValid(TxValid),
        .TxReady(rdy[1]), .TxOut(tx_out[1]), .TxBusy(bsy[1]));

    uart_xmit_controller #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0),
                           .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
        .Clock(Clock), .Reset(Reset), .TxData(TxData), .TxValid(TxValid),
        .TxReady(rdy[2]), .TxOut(tx_out[2]), .TxBusy(bsy[2]));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int checks = 0;
    int errors = 0;
    bit q0[$], q1[$], q2[$];
    logic [2:0] obs_tx, obs_bsy;
    bit accepted;

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic bit qfront(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic qpush(input int i, input bit b);
        case (i)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Expected line waveform for one frame, one entry per clock cycle.
    task automatic push_frame(input int i, input logic [7:0] d);
        bit bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (pen_cfg[i] != 0) bits.push_back((($countones(d) % 2) == 1) ^ (odd_cfg[i] != 0));
        for (int s = 0; s < stop_cfg[i]; s++) bits.push_back(1'b1);
        foreach (bits[j])
            for (int c = 0; c < CPB; c++) qpush(i, bits[j]);
    endtask

    task automatic cycle();
        bit ready_m;
        @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("txout%0d", i), 32'(tx_out[i]), (qsize(i) > 0) ? 32'(qfront(i)) : 32'd1);
            check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(qsize(i) <= 1));
            check($sformatf("busy%0d", i), 32'(bsy[i]), 32'(qsize(i) > 0));
        end
        obs_tx  = tx_out;
        obs_bsy = bsy;
        @(posedge Clock);
        accepted = 1'b0;
        if (Reset) begin
            clear_model();
        end else begin
            for (int i = 0; i < 3; i++) begin
                ready_m = (qsize(i) <= 1);
                if (qsize(i) > 0) qpop(i);
                if (TxValid && ready_m) begin
                    push_frame(i, TxData);
                    accepted = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d);
        TxData  = d;
        TxValid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            cycle();
            if (accepted) break;
        end
        check("accept_timeout", 32'(accepted), 32'd1);
        TxValid = 1'b0;
    endtask

    initial begin
        int gap;
        vecs[0] = '{8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1'b1};
        vecs[4] = '{8'hAA, 1'b0, 1'b1};
        vecs[5] = '{8'h3C, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b0, 1'b1};
        vecs[7] = '{8'h07, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 1'b1, 1'b0};

        Reset   = 1'b1;
        TxValid = 1'b0;
        TxData  = 8'h00;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_txout", 32'(tx_out[i]), 32'd1);
            check("reset_ready", 32'(rdy[i]), 32'd1);
            check("reset_busy", 32'(bsy[i]), 32'd0);
        end
        repeat (2) cycle();
        Reset = 1'b0;
        repeat (2) cycle();

        // Parity bit occupies cycles 37..40 after the accept edge
        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].data);
            repeat (38) cycle();
            check("parity_even", 32'(obs_tx[0]), 32'(vecs[v].par_even));
            check("parity_odd", 32'(obs_tx[1]), 32'(vecs[v].par_odd));
            repeat (8) cycle();
        end

        // Back-to-back: second start bit immediately after first frame's final stop cycle
        send_frame(8'h55);
        TxData  = 8'hAA;
        TxValid = 1'b1;
        gap = 0;
        for (int n = 0; n < 100; n++) begin
            cycle();
            gap++;
            if (accepted) break;
        end
        TxValid = 1'b0;
        check("b2b_spacing", 32'(gap), 32'd44);
        repeat (38) cycle();
        check("b2b_parity", 32'(obs_tx[0]), 32'd0);
        repeat (10) cycle();

        // TxValid during DATA is ignored
        send_frame(8'h96);
        repeat (10) cycle();
        TxData  = 8'hFF;
        TxValid = 1'b1;
        repeat (3) cycle();
        TxValid = 1'b0;
        repeat (40) cycle();
        check("ignored_no_frame", 32'(obs_bsy), 32'd0);

        // Asynchronous reset between clock edges mid-DATA
        send_frame(8'h5A);
        repeat (15) cycle();
        #2;
        Reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("async_txout", 32'(tx_out[i]), 32'd1);
            check("async_busy", 32'(bsy[i]), 32'd0);
        end
        clear_model();
        repeat (2) cycle();
        Reset = 1'b0;
        send_frame(8'h3C);
        repeat (38) cycle();
        check("post_reset_par_even", 32'(obs_tx[0]), 32'd0);
        check("post_reset_par_odd", 32'(obs_tx[1]), 32'd1);
        repeat (8) cycle();

        // Random traffic, including back-to-back and ignored requests
        for (int n = 0; n < 800; n++) begin
            TxValid = ($urandom_range(0, 3) != 0);
            TxData  = 8'($urandom);
            cycle();
        end
        TxValid = 1'b0;
        repeat (50) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_xmit_controller.md
# uart_xmit_controller

Transmit-side frame sequencer for the serial port. It accepts a parallel byte over a ready/valid handshake, serializes it LSB-first at a programmable bit period, and appends an optional parity bit and stop bit(s) onto `TxOut`. It sequences an internal `Xmit_ParityGenerator` instance, clearing it between frames and pulsing its enable once per data bit. It sits between the bus-side transmit register and the TX pin.

## Interface
- `DATA_BITS`, default 8: data bits per frame, valid range 5–8.
- `CLKS_PER_BIT`, default 16: `Clock` cycles per serial bit, must be ≥2.
- `PARITY_EN`, default 1: 1 appends a parity bit, 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

- `Clock` input, 1 bit: single clock. All state changes on its rising edge.
- `Reset` input, 1 bit: asynchronous, active-high.
- `TxData` input, `DATA_BITS` wide: byte to send. Sampled only on an accept.
- `TxValid` input, 1 bit: request to send `TxData`.
- `TxReady` output, 1 bit: controller can accept a byte.
- `TxOut` output, 1 bit: serial line. Idles high.
- `TxBusy` output, 1 bit: a frame is in progress (any state other than IDLE).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept occurs when `TxValid` and `TxReady` are both high at a rising edge. On accept, latch `TxData` into the shift register, load the baud counter with `CLKS_PER_BIT-1`, and enter START.
- The baud counter decrements every cycle. A bit ends when the counter is 0; the counter then reloads.
- START drives `TxOut`=0 for one bit period, then goes to DATA.
- DATA drives `TxOut` = `shift[0]`, one bit period per bit.
  - The bit index counts 0 to `DATA_BITS-1`.
  - On the last cycle of each bit, the shift register shifts right.
  - After the last bit, go to PARITY if `PARITY_EN`=1, else to STOP.
- Parity generator control:
  - Its `Reset` is asserted while the state is IDLE or STOP, or while `Reset` is high.
  - `Enable` is pulsed high for exactly one cycle, the first cycle of each DATA bit, with `Din` = `shift[0]`.
- PARITY drives `TxOut` = generator `Parity` XOR `PARITY_ODD` for one bit period.
- STOP drives `TxOut`=1 for `STOP_BITS` bit periods, then goes to IDLE.
- `TxReady` is high in IDLE and on the final cycle of the final stop bit.
  - An accept on that final cycle goes directly to START. Frames can therefore run back-to-back with no idle gap.
- `TxValid` while `TxReady` is low is ignored. `TxData` is not sampled and no error is flagged.

## Timing
- Reset values: state IDLE, `TxOut`=1, `TxReady`=1, `TxBusy`=0, counters 0, shift register 0.
- Assertion of `Reset` takes effect immediately, without waiting for a clock edge. A frame in progress is aborted and `TxOut` returns high.
- Latency: the falling edge of the start bit appears on `TxOut` in the first cycle after the accept edge.
- Frame length is (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- `TxOut` is registered, so it is glitch-free.
- The parity generator holds its final value from the last DATA `Enable` pulse until STOP clears it. This gives at least `CLKS_PER_BIT-1` cycles of margin before PARITY samples it.
- `TxBusy` goes high on the edge that accepts a byte. It goes low on the edge that enters IDLE, and stays high across back-to-back frames.

## Structure
- Shared package `uart_pkg`:
  - State enumeration type.
  - Width of the baud counter, `$clog2(CLKS_PER_BIT)`.
  - Width of the bit index, `$clog2(DATA_BITS)`.
  - Constant `LINE_IDLE`=1'b1.
- One sub-module: an `Xmit_ParityGenerator` instance named `u_parity`, driven as described under Operation.
- All other logic (FSM, baud counter, bit index, shift register) stays flat in this module.

## Test plan
- `CLKS_PER_BIT`=4, even parity, `TxData`=0xA5 accepted once → `TxOut` emits 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each bit held 4 cycles. Total 44 cycles, then `TxReady`=1.
- `TxData`=0x01 → parity bit is 1 with `PARITY_ODD`=0 and 0 with `PARITY_ODD`=1. `TxData`=0x00 with odd parity → parity bit is 1.
- `TxValid` held high with 0x55 then 0xAA presented → second start bit follows the first frame's stop bit with zero idle cycles. Second frame's parity reflects only 0xAA.
- `TxValid` pulsed during DATA of a frame in flight → ignored. The current frame completes unchanged and no second frame is sent.
- `Reset` asserted mid-DATA between clock edges → `TxOut`=1 and `TxBusy`=0 without a clock edge. After release, a new 0x3C frame has correct parity.
- `PARITY_EN`=0, `STOP_BITS`=2, `CLKS_PER_BIT`=4 → frame is 44 cycles with no parity bit and two high stop bits.
